case_9_mul_share_arb: RTL and testbench

//  Round-robin arbiter/sequencer sharing one combinational signed multiplier (8s x 2s -> 10,

---
 rtl/case_9_mul_share_arb.sv | 137 +++++++++++++
 tb/tb_case_9_mul_share_arb.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/case_9_mul_share_arb.sv
// Round-robin sequencer that shares one external combinational signed multiplier among NUM_REQ requesters.
// Define MUL_ARB_TXN_CNT_EN to add the saturating txn_cnt accept counter output.
module case_9_mul_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2,
  parameter int unsigned A_W     = 8,
  parameter int unsigned B_W     = 2,
  parameter int unsigned P_W     = 10
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic [A_W-1:0]         mul_din0,
  output logic [B_W-1:0]         mul_din1,
  input  logic [P_W-1:0]         mul_dout,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [P_W-1:0]         res_data,
  output logic [ID_W-1:0]        res_id
`ifdef MUL_ARB_TXN_CNT_EN
  ,
  output logic [31:0]            txn_cnt
`endif
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_e;

  state_e            state_q;
  logic              res_valid_q;
  logic [P_W-1:0]    res_data_q;
  logic [ID_W-1:0]   res_id_q;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   ptr_d;

  logic              can_issue;
  logic              gnt_vld;
  logic [ID_W-1:0]   gnt_idx;
  logic [31:0]       idx;
  logic              accept;

  // Rotating priority search starting at ptr_q; grants are suppressed while reset is held.
  always_comb begin
    can_issue = ~ap_rst & ((state_q == EMPTY) | (res_valid_q & res_ready));
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = 32'(ptr_q) + k;
      if (idx >= NUM_REQ) begin
        idx = idx - NUM_REQ;
      end
      if (can_issue && !gnt_vld && req_valid[idx[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx[ID_W-1:0];
      end
    end
  end

  assign accept = gnt_vld;

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_vld && (gnt_idx == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        mul_din0     = req_a[i*A_W +: A_W];
        mul_din1     = req_b[i*B_W +: B_W];
      end
    end
    ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q     <= EMPTY;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      ptr_q       <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            state_q     <= FULL;
            res_valid_q <= 1'b1;
            res_data_q  <= mul_dout;
            res_id_q    <= gnt_idx;
            ptr_q       <= ptr_d;
          end
        end
        FULL: begin
          // Drain and refill in the same cycle keeps the register full.
          if (accept) begin
            res_valid_q <= 1'b1;
            res_data_q  <= mul_dout;
            res_id_q    <= gnt_idx;
            ptr_q       <= ptr_d;
          end else if (res_ready) begin
            state_q     <= EMPTY;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= EMPTY;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_id    = res_id_q;

`ifdef MUL_ARB_TXN_CNT_EN
  logic [31:0] txn_cnt_q;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      txn_cnt_q <= '0;
    end else if (accept && (txn_cnt_q != '1)) begin
      txn_cnt_q <= txn_cnt_q + 32'd1;
    end
  end

  assign txn_cnt = txn_cnt_q;
`endif

endmodule

// File: tb/tb_case_9_mul_share_arb.sv
// Directed bench for case_9_mul_share_arb: a transaction-level model checked every cycle,
// plus hand-computed expectations for the reset, single-request, round-robin, backpressure and skip cases.
module tb_case_9_mul_share_arb;

  logic        clk;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [31:0] req_a;
  logic [7:0]  req_b;
  logic [7:0]  mul_din0;
  logic [1:0]  mul_din1;
  logic [9:0]  mul_dout;
  logic        res_valid;
  logic        res_ready;
  logic [9:0]  res_data;
  logic [1:0]  res_id;
`ifdef MUL_ARB_TXN_CNT_EN
  logic [31:0] txn_cnt;
`endif

  logic signed [7:0] a_arr [4];
  logic signed [1:0] b_arr [4];

  int total = 0;
  int bad   = 0;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      req_a[i*8 +: 8] = a_arr[i];
      req_b[i*2 +: 2] = b_arr[i];
    end
  end

  // The bench plays the role of the shared external multiplier.
  assign mul_dout = 10'($signed(mul_din0) * $signed(mul_din1));

  case_9_mul_share_arb #(
    .NUM_REQ(4),
    .ID_W   (2),
    .A_W    (8),
    .B_W    (2),
    .P_W    (10)
  ) dut (
    .ap_clk   (clk),
    .ap_rst   (ap_rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_a    (req_a),
    .req_b    (req_b),
    .mul_din0 (mul_din0),
    .mul_din1 (mul_din1),
    .mul_dout (mul_dout),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data (res_data),
    .res_id   (res_id)
`ifdef MUL_ARB_TXN_CNT_EN
    ,
    .txn_cnt  (txn_cnt)
`endif
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one result slot, a rotating start index, a running count.
  bit          m_known = 0;
  bit          m_full;
  logic [9:0]  m_data;
  int          m_id;
  int          m_ptr;
  logic [31:0] m_cnt;

  always @(negedge clk) begin
    int         g;
    int         idx;
    logic [3:0] er;
    logic [7:0] e0;
    logic [1:0] e1;
    if (m_known) begin
      g = -1;
      if (!ap_rst && (!m_full || res_ready)) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      er = '0;
      e0 = '0;
      e1 = '0;
      if (g >= 0) begin
        er[g] = 1'b1;
        e0    = a_arr[g];
        e1    = b_arr[g];
      end
      chk("m_req_ready", 32'(req_ready), 32'(er));
      chk("m_mul_din0",  32'(mul_din0),  32'(e0));
      chk("m_mul_din1",  32'(mul_din1),  32'(e1));
      chk("m_res_valid", 32'(res_valid), 32'(m_full));
      chk("m_res_data",  32'(res_data),  32'(m_data));
      chk("m_res_id",    32'(res_id),    32'(m_id));
`ifdef MUL_ARB_TXN_CNT_EN
      chk("m_txn_cnt",   txn_cnt,        m_cnt);
`endif
      if (!ap_rst) begin
        if (g >= 0) begin
          m_full = 1'b1;
          m_data = 10'(int'(a_arr[g]) * int'(b_arr[g]));
          m_id   = g;
          m_ptr  = (g + 1) % 4;
          if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end else if (m_full && res_ready) begin
          m_full = 1'b0;
        end
      end
    end
    if (ap_rst) begin
      m_known = 1'b1;
      m_full  = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
      m_cnt   = '0;
    end
  end

  typedef struct {
    logic [3:0] v;
    logic       rr;
  } pat_t;

  pat_t pats [11];

  initial begin
    logic [9:0] t3_data [4];

    ap_rst    = 1'b1;
    req_valid = 4'b1111;
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_arr[i] = '0;
      b_arr[i] = '0;
    end

    // Reset held with every requester asking.
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("t1_req_ready", 32'(req_ready), 32'h0);
      chk("t1_res_valid", 32'(res_valid), 32'h0);
      chk("t1_res_data",  32'(res_data),  32'h0);
    end

    @(posedge clk); #1;
    ap_rst    = 1'b0;
    a_arr[0]  = -8'sd128;
    b_arr[0]  = -2'sd2;
    req_valid = 4'b0001;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t2_req_ready", 32'(req_ready), 32'h1);
    chk("t2_mul_din0",  32'(mul_din0),  32'h80);

    @(posedge clk); #1;
    req_valid = 4'b0000;
    ap_rst    = 1'b1;
    @(negedge clk);
    chk("t2_res_valid", 32'(res_valid), 32'h1);
    chk("t2_res_data",  32'($signed(res_data)), 256);
    chk("t2_res_id",    32'(res_id), 32'h0);

    // Round robin with all four asking and the sink always ready.
    @(posedge clk); #1;
    ap_rst   = 1'b0;
    a_arr[0] = 8'sd5;    b_arr[0] = 2'sd1;
    a_arr[1] = -8'sd3;   b_arr[1] = -2'sd1;
    a_arr[2] = 8'sd100;  b_arr[2] = -2'sd2;
    a_arr[3] = -8'sd7;   b_arr[3] = 2'sd1;
    t3_data[0] = 10'h005;
    t3_data[1] = 10'h003;
    t3_data[2] = 10'h338;
    t3_data[3] = 10'h3F9;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (k == 4) res_ready = 1'b0;
      @(negedge clk);
      chk("t3_res_valid", 32'(res_valid), 32'h1);
      chk("t3_res_id",    32'(res_id),    32'(k % 4));
      chk("t3_res_data",  32'(res_data),  32'(t3_data[k % 4]));
    end

    // Backpressure: requester 0's product of 5 stays put and nobody is granted.
    chk("t4_req_ready", 32'(req_ready), 32'h0);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("t4_hold_data",  32'($signed(res_data)), 5);
      chk("t4_hold_id",    32'(res_id),    32'h0);
      chk("t4_hold_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t4_release_ready", 32'(req_ready), 32'h2);

    // Only requesters 1 and 3 ask while the pointer sits at 2.
    @(posedge clk); #1;
    req_valid = 4'b1010;
    a_arr[3] = 8'sd127; b_arr[3] = -2'sd1;
    a_arr[1] = -8'sd1;  b_arr[1] = 2'sd1;
    @(negedge clk);
    chk("t4_next_id",   32'(res_id),    32'h1);
    chk("t5_grant3",    32'(req_ready), 32'h8);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_res_data3", 32'($signed(res_data)), -127);
    chk("t5_res_id3",   32'(res_id),    32'h3);
    chk("t5_grant1",    32'(req_ready), 32'h2);
    @(posedge clk); #1;
    req_valid = 4'b0000;
    res_ready = 1'b0;
    @(negedge clk);
    chk("t5_res_data1", 32'($signed(res_data)), -1);
    chk("t5_res_id1",   32'(res_id),    32'h1);

    // Reset while a result is held drops it and rewinds the pointer.
    @(posedge clk); #1;
    ap_rst = 1'b1;
    @(negedge clk);
    chk("t6_pre_valid", 32'(res_valid), 32'h1);
    @(posedge clk); #1;
    ap_rst    = 1'b0;
    a_arr[0]  = 8'sd127;
    b_arr[0]  = -2'sd2;
    a_arr[2]  = -8'sd128;
    b_arr[2]  = 2'sd1;
    req_valid = 4'b1111;
    res_ready = 1'b1;
    @(negedge clk);
    chk("t6_res_valid", 32'(res_valid), 32'h0);
    chk("t6_res_data",  32'(res_data),  32'h0);
    chk("t6_ptr_zero",  32'(req_ready), 32'h1);

    // Mixed request/sink patterns, checked by the model alone.
    pats[0]  = '{4'b1111, 1'b1};
    pats[1]  = '{4'b0101, 1'b1};
    pats[2]  = '{4'b0000, 1'b1};
    pats[3]  = '{4'b1111, 1'b0};
    pats[4]  = '{4'b1111, 1'b0};
    pats[5]  = '{4'b1111, 1'b1};
    pats[6]  = '{4'b1000, 1'b1};
    pats[7]  = '{4'b0001, 1'b0};
    pats[8]  = '{4'b0001, 1'b1};
    pats[9]  = '{4'b0110, 1'b1};
    pats[10] = '{4'b0000, 1'b1};
    for (int p = 0; p < 11; p++) begin
      @(posedge clk); #1;
      req_valid = pats[p].v;
      res_ready = pats[p].rr;
    end
    @(posedge clk); #1;
    req_valid = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
